// File: rtl/ec_mult_arbiter.sv
// ec_mult_arbiter: round-robin sharing of one gen_point scalar-multiply engine among NUM_REQ requesters.
// Define EC_ARB_TIMEOUT_EN to enable the RUN-state watchdog and resp_err.
module ec_mult_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ENG_RST_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*256-1:0] req_key,
  input  logic [NUM_REQ*512-1:0] req_point,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [511:0]           resp_point,
  output logic                   resp_err,
  output logic                   busy
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CMAX = ENG_RST_CYCLES > TIMEOUT_CYCLES ? ENG_RST_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} st_t;
  st_t st, st_n;
  logic [IW-1:0] rr_ptr, grant_r, sel;
  logic found, eng_rst, eng_done, tmo;
  logic [255:0] key_r;
  logic [511:0] pt_r, res_r, out_point;
  logic [CW-1:0] cnt_r;
`ifdef EC_ARB_TIMEOUT_EN
  logic err_r;
  assign tmo = cnt_r == CW'(TIMEOUT_CYCLES - 1);
  assign resp_err = (st == RESP) && err_r;
`else
  assign tmo = 1'b0;
  assign resp_err = 1'b0;
`endif
  gen_point u_eng (
    .clk(clk),
    .Reset(eng_rst),
    .privKey(key_r),
    .in_point(pt_r),
    .out_point(out_point),
    .Done(eng_done)
  );
  always_comb begin
    int idx;
    idx = 0;
    sel = rr_ptr;
    found = 1'b0;
    for (int j = 1; j <= NUM_REQ; j++) begin
      idx = (int'(rr_ptr) + j) % NUM_REQ;
      if (!found && req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        sel = idx[IW-1:0];
      end
    end
  end
  always_comb begin
    st_n = st;
    case (st)
      IDLE: st_n = found ? LOAD : IDLE;
      LOAD: st_n = (cnt_r == CW'(ENG_RST_CYCLES - 1)) ? RUN : LOAD;
      RUN: st_n = (eng_done || tmo) ? RESP : RUN;
      RESP: st_n = resp_ready[grant_r] ? IDLE : RESP;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      st <= IDLE;
      rr_ptr <= IW'(NUM_REQ - 1);
      grant_r <= '0;
      cnt_r <= '0;
      res_r <= '0;
`ifdef EC_ARB_TIMEOUT_EN
      err_r <= 1'b0;
`endif
    end else begin
      st <= st_n;
      case (st)
        IDLE: if (found) begin
          key_r <= req_key[256*sel +: 256];
          pt_r <= req_point[512*sel +: 512];
          grant_r <= sel;
          rr_ptr <= sel;
          cnt_r <= '0;
        end
        LOAD: cnt_r <= (st_n == RUN) ? '0 : cnt_r + CW'(1);
        RUN: begin
          res_r <= eng_done ? out_point : res_r;
`ifdef EC_ARB_TIMEOUT_EN
          cnt_r <= cnt_r + CW'(1);
          if (!eng_done && tmo) begin
            res_r <= '0;
            err_r <= 1'b1;
          end
`endif
        end
        RESP: begin
`ifdef EC_ARB_TIMEOUT_EN
          if (st_n == IDLE) err_r <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end
  assign req_ready = (st == IDLE && found && !Reset) ? NUM_REQ'(1) << sel : '0;
  assign resp_valid = (st == RESP) ? NUM_REQ'(1) << grant_r : '0;
  assign resp_point = (st == RESP) ? res_r : '0;
  assign busy = st != IDLE;
  assign eng_rst = Reset || st != RUN;
endmodule

// Affine double-and-add over secp256k1; the point at infinity is reported as (0,0).
module gen_point (
  input  logic         clk,
  input  logic         Reset,
  input  logic [255:0] privKey,
  input  logic [511:0] in_point,
  output logic [511:0] out_point,
  output logic         Done
);
  localparam logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  function automatic logic [255:0] addm(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, P}) ? 256'(s - {1'b0, P}) : s[255:0];
  endfunction
  function automatic logic [255:0] subm(input logic [255:0] a, input logic [255:0] b);
    return (a >= b) ? a - b : a - b + P;
  endfunction
  function automatic logic [255:0] halfm(input logic [255:0] a);
    logic [256:0] s;
    s = a[0] ? {1'b0, a} + {1'b0, P} : {1'b0, a};
    return s[256:1];
  endfunction
  typedef enum logic [3:0] {G_LOAD, G_BIT, G_DSQ, G_DINV, G_DLAM, G_ADD, G_AINV, G_ALAM, G_TSQ, G_TY, G_DONE} gst_t;
  gst_t st, st_n;
  logic [255:0] kr, px, py, rx, ry, t0, t1, lam;
  logic rinf, dbl, adding, ph;
  logic [8:0] cnt;
  logic [255:0] ma, mb, maa, mbb, macc, mstep, ia, iu, iv, ix1, ix2, ir;
  logic [7:0] mcnt;
  logic m_go, m_rdy, mrun, i_go, i_rdy, irun, fin_m, fin_i, adv_add;
  assign fin_m = ph && m_rdy;
  assign fin_i = ph && i_rdy;
  assign adv_add = !adding && kr[255];
  always_comb begin
    st_n = st;
    m_go = 1'b0;
    i_go = 1'b0;
    ma = rx;
    mb = rx;
    ia = addm(ry, ry);
    case (st)
      G_LOAD: st_n = G_BIT;
      G_BIT: st_n = (cnt == 9'd256) ? G_DONE : (rinf ? G_BIT : G_DSQ);
      G_DSQ: begin
        m_go = !ph;
        st_n = fin_m ? G_DINV : st;
      end
      G_DINV: begin
        i_go = !ph;
        st_n = fin_i ? G_DLAM : st;
      end
      G_DLAM: begin
        ma = t0;
        mb = t1;
        m_go = !ph;
        st_n = fin_m ? G_TSQ : st;
      end
      G_ADD: st_n = (rx != px) ? G_AINV : (ry == py) ? G_DSQ : G_BIT;
      G_AINV: begin
        ia = subm(px, rx);
        i_go = !ph;
        st_n = fin_i ? G_ALAM : st;
      end
      G_ALAM: begin
        ma = subm(py, ry);
        mb = t1;
        m_go = !ph;
        st_n = fin_m ? G_TSQ : st;
      end
      G_TSQ: begin
        ma = lam;
        mb = lam;
        m_go = !ph;
        st_n = fin_m ? G_TY : st;
      end
      G_TY: begin
        ma = lam;
        mb = subm(rx, t0);
        m_go = !ph;
        st_n = fin_m ? (adv_add ? G_ADD : G_BIT) : st;
      end
      G_DONE: st_n = G_DONE;
      default: st_n = G_LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      st <= G_LOAD;
      ph <= 1'b0;
      rinf <= 1'b1;
      cnt <= '0;
    end else begin
      st <= st_n;
      ph <= (st_n == st) && (ph || m_go || i_go);
      case (st)
        G_LOAD: begin
          kr <= privKey;
          px <= in_point[511:256];
          py <= in_point[255:0];
          rinf <= 1'b1;
          cnt <= '0;
        end
        G_BIT: if (cnt != 9'd256 && rinf) begin
          if (kr[255]) begin
            rx <= px;
            ry <= py;
            rinf <= 1'b0;
          end
          kr <= kr << 1;
          cnt <= cnt + 9'd1;
        end else begin
          dbl <= 1'b1;
          adding <= 1'b0;
        end
        G_DSQ: if (fin_m) t0 <= addm(addm(macc, macc), macc);
        G_DINV, G_AINV: if (fin_i) t1 <= ir;
        G_DLAM, G_ALAM: if (fin_m) lam <= macc;
        G_ADD: begin
          dbl <= rx == px;
          if (rx == px && ry != py) begin
            rinf <= 1'b1;
            kr <= kr << 1;
            cnt <= cnt + 9'd1;
          end
        end
        G_TSQ: if (fin_m) t0 <= subm(subm(macc, rx), dbl ? rx : px);
        G_TY: if (fin_m) begin
          rx <= t0;
          ry <= subm(macc, ry);
          if (adv_add) adding <= 1'b1;
          else begin
            kr <= kr << 1;
            cnt <= cnt + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end
  // Bit-serial MSB-first interleaved modular multiply, 256 cycles.
  assign mstep = mbb[255] ? addm(addm(macc, macc), maa) : addm(macc, macc);
  always_ff @(posedge clk) begin
    if (Reset) begin
      mrun <= 1'b0;
      m_rdy <= 1'b0;
    end else begin
      m_rdy <= mrun && mcnt == 8'd255;
      if (m_go) begin
        maa <= ma;
        mbb <= mb;
        macc <= '0;
        mcnt <= '0;
        mrun <= 1'b1;
      end else if (mrun) begin
        macc <= mstep;
        mbb <= mbb << 1;
        mcnt <= mcnt + 8'd1;
        mrun <= mcnt != 8'd255;
      end
    end
  end
  // Binary extended Euclid inverse; a zero operand yields zero rather than spinning.
  always_ff @(posedge clk) begin
    if (Reset) begin
      irun <= 1'b0;
      i_rdy <= 1'b0;
    end else begin
      i_rdy <= 1'b0;
      if (i_go) begin
        iu <= ia;
        iv <= P;
        ix1 <= 256'd1;
        ix2 <= '0;
        irun <= 1'b1;
      end else if (irun) begin
        if (iu == 256'd1 || iv == 256'd1 || iu == '0) begin
          irun <= 1'b0;
          i_rdy <= 1'b1;
          ir <= (iu == 256'd1) ? ix1 : (iv == 256'd1) ? ix2 : '0;
        end else if (!iu[0]) begin
          iu <= iu >> 1;
          ix1 <= halfm(ix1);
        end else if (!iv[0]) begin
          iv <= iv >> 1;
          ix2 <= halfm(ix2);
        end else if (iu >= iv) begin
          iu <= iu - iv;
          ix1 <= subm(ix1, ix2);
        end else begin
          iv <= iv - iu;
          ix2 <= subm(ix2, ix1);
        end
      end
    end
  end
  assign out_point = rinf ? '0 : {rx, ry};
  assign Done = st == G_DONE;
endmodule

// File: tb/tb_ec_mult_arbiter.sv
// tb_ec_mult_arbiter: directed checks of arbitration, handshakes and secp256k1 results.
module tb_ec_mult_arbiter;
  localparam int N = 2;
  localparam int E = 2;
`ifdef EC_ARB_TIMEOUT_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 200000;
`endif
  localparam logic [511:0] G  = {256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798,
                                 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8};
  localparam logic [511:0] G2 = {256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5,
                                 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A};
  localparam logic [511:0] G3 = {256'hF9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9,
                                 256'h388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672};
  logic clk = 1'b0;
  logic Reset = 1'b1;
  logic [N-1:0] req_valid = '0, resp_ready = '0, req_ready, resp_valid;
  logic [N*256-1:0] req_key = '0;
  logic [N*512-1:0] req_point = {G, G};
  logic [511:0] resp_point, held;
  logic resp_err, busy;
  int vectors = 0, miscompares = 0;
  bit flag;
  always #5 clk = ~clk;
  ec_mult_arbiter #(.NUM_REQ(N), .ENG_RST_CYCLES(E), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_point(req_point), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_point(resp_point), .resp_err(resp_err), .busy(busy)
  );
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_job(input int r, input logic [255:0] k);
    req_key[256*r +: 256] = k;
    req_valid[r] = 1'b1;
    #1;
    chk("req_ready_grant", req_ready, 1 << r);
    tick();
    req_valid[r] = 1'b0;
    #1;
    chk("busy_after_accept", busy, 1);
  endtask
  task automatic wait_resp();
    int n = 0;
    flag = 0;
    while (resp_valid == '0 && n < 20000) begin
      if (req_ready != '0) flag = 1;
      tick();
      n++;
    end
    chk("resp_arrives", resp_valid != '0, 1);
    chk("no_req_ready_while_busy", flag, 0);
  endtask
  task automatic end_job(input int r, input logic [511:0] exp);
    chk("resp_valid_owner", resp_valid, 1 << r);
    chk("resp_point", resp_point, exp);
    chk("resp_err", resp_err, 0);
    resp_ready[r] = 1'b1;
    #1;
    chk("no_req_ready_in_resp", req_ready, 0);
    tick();
    resp_ready[r] = 1'b0;
    #1;
    chk("busy_after_resp", busy, 0);
    chk("resp_valid_cleared", resp_valid, 0);
  endtask
  task automatic job(input int r, input logic [255:0] k, input logic [511:0] exp);
    start_job(r, k);
    wait_resp();
    end_job(r, exp);
  endtask
  initial begin
    req_valid = 2'b11;
    repeat (3) tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_point", resp_point, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    Reset = 1'b0;
    #1;
    chk("first_priority_req0", req_ready, 2'b01);
    req_valid = '0;
`ifdef EC_ARB_TIMEOUT_EN
    start_job(0, 256'd2);
    repeat (E + TMO - 1) tick();
    chk("tmo_not_early", resp_valid, 0);
    tick();
    chk("tmo_resp_valid", resp_valid, 2'b01);
    chk("tmo_resp_err", resp_err, 1);
    chk("tmo_resp_point", resp_point, 0);
    resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0;
    #1;
    chk("tmo_err_cleared", resp_err, 0);
    chk("tmo_busy_cleared", busy, 0);
`else
    start_job(0, 256'd1);
    wait_resp();
    held = resp_point;
    req_key[256 +: 256] = 256'd2;
    req_valid[1] = 1'b1;
    resp_ready[1] = 1'b1;
    flag = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (resp_point !== held || req_ready != '0 || resp_valid != 2'b01) flag = 1;
    end
    resp_ready[1] = 1'b0;
    chk("stall_stable", flag, 0);
    end_job(0, G);
    start_job(1, 256'd2);
    wait_resp();
    end_job(1, G2);
    job(0, 256'd0, 512'd0);
    job(1, 256'd3, G3);
    req_key = {256'd2, 256'd1};
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", req_ready, 1 << (i % 2));
      tick();
      wait_resp();
      end_job(i % 2, (i % 2) ? G2 : G);
    end
    req_valid = '0;
    start_job(0, 256'd2);
    repeat (100) tick();
    Reset = 1'b1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_resp_point", resp_point, 0);
    chk("midrst_resp_err", resp_err, 0);
    chk("midrst_req_ready", req_ready, 0);
    Reset = 1'b0;
    flag = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (resp_valid != '0) flag = 1;
    end
    chk("midrst_no_resp", flag, 0);
    job(0, 256'd1, G);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
